ff_wavegen: RTL and testbench

- Parametrised multi-channel successor to the single-output flip-flop toggler.
- Each of NCH channels drives a registered square/pulse waveform on opin[ch]. High and low phase lengths are programmable in clock cycles.
- Each channel runs free-running or one-shot.
- Sits between the control/config logic and downstream timing consumers. Benches observe its first-high/first-low edges after reset.

---
 rtl/ff_wavegen.sv | 163 ++++++++++++++++
 tb/tb_ff_wavegen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ff_wavegen.sv
// ff_wavegen: NCH independent square/pulse generators with programmable high/low phase lengths.
// Define FF_WAVEGEN_PCNT_EN to add per-channel saturating completed-period counters on pcnt.
module ff_wavegen #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_HIGH = 5,
    parameter int DEF_LOW  = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NCH-1:0]                        en,
    input  logic [NCH-1:0]                        mode,
    input  logic                                  cfg_wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_high,
    input  logic [CNT_W-1:0]                      cfg_low,
    output logic [NCH-1:0]                        opin,
    output logic [NCH-1:0]                        busy,
    output logic [NCH-1:0]                        done
`ifdef FF_WAVEGEN_PCNT_EN
    ,
    output logic [NCH*16-1:0]                     pcnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] high_q, low_q, sh_high_q, sh_low_q;
        logic [CNT_W-1:0] high_last, low_last;
        logic             pend_q;
        logic             hold_q, hold_d;
        logic             load, done_d;
        logic             opin_q, busy_q, done_q;
        logic             wr_hit;

        // A programmed length of zero behaves as one cycle.
        assign high_last = (high_q == '0) ? '0 : high_q - CNT_W'(1);
        assign low_last  = (low_q == '0) ? '0 : low_q - CNT_W'(1);
        assign wr_hit    = cfg_wr && (int'(cfg_ch) == i);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            load    = 1'b0;
            done_d  = 1'b0;
            hold_d  = hold_q;
            // hold blocks a finished one-shot from restarting until en drops
            if (!en[i]) begin
                hold_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (en[i] && !hold_q) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
                HIGH: begin
                    if (!en[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == high_last) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (!en[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == low_last) begin
                        cnt_d = '0;
                        if (mode[i]) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            hold_d  = 1'b1;
                        end else begin
                            state_d = HIGH;
                            load    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A write landing on a boundary edge re-arms pending after the load clears it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                high_q    <= CNT_W'(DEF_HIGH);
                low_q     <= CNT_W'(DEF_LOW);
                sh_high_q <= CNT_W'(DEF_HIGH);
                sh_low_q  <= CNT_W'(DEF_LOW);
                pend_q    <= 1'b0;
                hold_q    <= 1'b0;
                opin_q    <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                opin_q  <= (state_d == HIGH);
                busy_q  <= (state_d != IDLE);
                done_q  <= done_d;
                if (load && pend_q) begin
                    high_q <= sh_high_q;
                    low_q  <= sh_low_q;
                    pend_q <= 1'b0;
                end
                if (wr_hit) begin
                    sh_high_q <= cfg_high;
                    sh_low_q  <= cfg_low;
                    pend_q    <= 1'b1;
                end
            end
        end

        assign opin[i] = opin_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;

`ifdef FF_WAVEGEN_PCNT_EN
        logic [15:0] pcnt_q;
        logic        period_end;
        logic        run_start;

        assign period_end = (state_q == LOW) && en[i] && (cnt_q == low_last);
        assign run_start  = (state_q == IDLE) && (state_d == HIGH);

        // Counts completed periods since the last start from IDLE, saturating.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pcnt_q <= '0;
            end else if (run_start) begin
                pcnt_q <= '0;
            end else if (period_end && (pcnt_q != 16'hFFFF)) begin
                pcnt_q <= pcnt_q + 16'd1;
            end
        end

        assign pcnt[i*16 +: 16] = pcnt_q;
`endif
    end

endmodule

// File: tb/tb_ff_wavegen.sv
// tb_ff_wavegen: directed self-checking bench for ff_wavegen with hand-computed waveforms.
module tb_ff_wavegen;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   mode;
    logic             cfg_wr;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [NCH-1:0]   opin;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;
`ifdef FF_WAVEGEN_PCNT_EN
    logic [NCH*16-1:0] pcnt;
`endif

    int errors = 0;
    int checks = 0;

    ff_wavegen #(
        .NCH(NCH),
        .CNT_W(CNT_W),
        .DEF_HIGH(5),
        .DEF_LOW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch),
        .cfg_high(cfg_high),
        .cfg_low(cfg_low),
        .opin(opin),
        .busy(busy),
        .done(done)
`ifdef FF_WAVEGEN_PCNT_EN
        ,
        .pcnt(pcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [CNT_W-1:0] hi,
                                 input logic [CNT_W-1:0] lo);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_high = hi;
        cfg_low  = lo;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic doReset();
        rst      = 1'b0;
        en       = '0;
        mode     = '0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_high = '0;
        cfg_low  = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] pat16;
        logic [22:0] pat23;

        // Reset state
        doReset();
        checkOutput("reset_opin", 32'(opin), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);

        // Defaults 5/5 on ch0, first high on the sampling edge
        en[0] = 1'b1;
        pat16 = 16'b1111100000110000;
        for (int n = 1; n <= 12; n++) begin
            step();
            checkOutput($sformatf("def_ch0_e%0d", n), 32'(opin[0]), 32'(pat16[16-n]));
        end
        checkOutput("def_busy_ch0", 32'(busy[0]), 32'h1);

        // ch1 programmed 3/2, then dropped mid-HIGH
        doReset();
        applyStimulus(2'd1, 16'd3, 16'd2);
        en[1] = 1'b1;
        pat16 = 16'b1110011100100000;
        for (int n = 1; n <= 11; n++) begin
            step();
            checkOutput($sformatf("ch1_opin_e%0d", n), 32'(opin[1]), 32'(pat16[16-n]));
            checkOutput($sformatf("ch1_busy_e%0d", n), 32'(busy[1]), 32'h1);
        end
        en[1] = 1'b0;
        step();
        checkOutput("ch1_drop_opin", 32'(opin[1]), 32'h0);
        checkOutput("ch1_drop_busy", 32'(busy[1]), 32'h0);
        checkOutput("ch1_drop_done", 32'(done[1]), 32'h0);

        // ch0 reprogrammed mid-period, then a write on a boundary edge
        doReset();
        en[0] = 1'b1;
        pat23 = 23'b11111000001101101110001;
        for (int n = 1; n <= 23; n++) begin
            step();
            checkOutput($sformatf("shadow_e%0d", n), 32'(opin[0]), 32'(pat23[23-n]));
            cfg_wr = 1'b0;
            if (n == 2) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_high = 16'd2; cfg_low = 16'd1;
            end
            if (n == 13) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_high = 16'd3; cfg_low = 16'd3;
            end
        end

        // ch2 one-shot 4/3 with done pulse and re-arm
        doReset();
        applyStimulus(2'd2, 16'd4, 16'd3);
        mode[2] = 1'b1;
        en[2]   = 1'b1;
        pat16   = 16'b1111000000000000;
        for (int n = 1; n <= 10; n++) begin
            step();
            checkOutput($sformatf("os_opin_e%0d", n), 32'(opin[2]), 32'(pat16[16-n]));
            checkOutput($sformatf("os_done_e%0d", n), 32'(done[2]), (n == 8) ? 32'h1 : 32'h0);
            checkOutput($sformatf("os_busy_e%0d", n), 32'(busy[2]), (n <= 7) ? 32'h1 : 32'h0);
        end
        en[2] = 1'b0;
        step();
        en[2] = 1'b1;
        step();
        checkOutput("os_rearm_opin", 32'(opin[2]), 32'h1);
        for (int n = 1; n <= 7; n++) step();
        checkOutput("os_rearm_done", 32'(done[2]), 32'h1);
        checkOutput("os_rearm_idle", 32'(busy[2]), 32'h0);

        // ch3 with zero lengths toggles, then async reset mid-HIGH
        doReset();
        applyStimulus(2'd3, 16'd0, 16'd0);
        en[3] = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            checkOutput($sformatf("zero_e%0d", n), 32'(opin[3]), (n % 2 == 1) ? 32'h1 : 32'h0);
        end
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_opin", 32'(opin[3]), 32'h0);
        checkOutput("async_rst_busy", 32'(busy[3]), 32'h0);
        en[3] = 1'b0;
        step();
        rst   = 1'b1;
        en[3] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            checkOutput($sformatf("post_rst_e%0d", n), 32'(opin[3]), (n <= 5) ? 32'h1 : 32'h0);
        end

`ifdef FF_WAVEGEN_PCNT_EN
        // Period counter at 1/1 and restart from IDLE
        doReset();
        applyStimulus(2'd0, 16'd1, 16'd1);
        en[0] = 1'b1;
        for (int n = 1; n <= 21; n++) step();
        checkOutput("pcnt_ten", 32'(pcnt[15:0]), 32'd10);
        en[0] = 1'b0;
        step();
        en[0] = 1'b1;
        step();
        checkOutput("pcnt_restart", 32'(pcnt[15:0]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
